// File: rtl/chunked_period_timer.sv
// chunked_period_timer: prescaler/timeout strobe with a chunked carry-pipelined tick counter.
// Optional sticky overrun detection is built when CHUNKED_TIMER_OVERRUN_EN is defined;
// otherwise overrun is tied low.
module chunked_period_timer #(
    parameter int WIDTH          = 16,
    parameter int LATENCY        = 4,
    parameter int DEFAULT_PERIOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic             oneshot,
    output logic             strobe,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic             overrun
);
    localparam int ALU_WIDTH       = (WIDTH + LATENCY - 1) / LATENCY;
    localparam int CHUNK_COUNT     = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;
    localparam int LAST_CHUNK_SIZE = WIDTH - (CHUNK_COUNT - 1) * ALU_WIDTH;
    localparam int CW              = CHUNK_COUNT > 1 ? CHUNK_COUNT - 1 : 1;

    logic [WIDTH-1:0]       period;
    logic [WIDTH-1:0]       sum;
    logic                   mode;
    logic [CW-1:0]          cy;
    logic [CW-1:0]          cout;
    logic [CW-1:0]          fl;
    logic [CHUNK_COUNT-1:0] cin;
    logic [CHUNK_COUNT-1:0] hp;
    logic [CHUNK_COUNT:0]   hv;
    logic                   acc;
    logic                   hit;
    logic                   wrap;

    // count is settled whenever a tick is accepted, so the period match is decided at acceptance
    assign acc    = enable & ready & ~done & (period != '0);
    assign hit    = count == period - WIDTH'(1);
    assign hv     = {hp, acc & hit};
    assign wrap   = hv[CHUNK_COUNT-1];
    assign strobe = hv[CHUNK_COUNT];
    assign ready  = (CHUNK_COUNT == 1) | ~|fl;

    for (genvar g = 0; g < CHUNK_COUNT; g++) begin : g_chunk
        localparam int LO = g * ALU_WIDTH;
        localparam int W  = (g == CHUNK_COUNT - 1) ? LAST_CHUNK_SIZE : ALU_WIDTH;
        localparam int W1 = W + 1;
        if (g == 0) begin : g_first
            assign cin[g] = acc;
        end else begin : g_rest
            assign cin[g] = cy[g-1];
        end
        if (g == CHUNK_COUNT - 1) begin : g_top
            assign sum[LO +: W] = count[LO +: W] + W'(cin[g]);
        end else begin : g_mid
            assign {cout[g], sum[LO +: W]} = {1'b0, count[LO +: W]} + W1'(cin[g]);
        end
    end
    if (CHUNK_COUNT == 1) begin : g_single
        assign cout = 1'b0;
    end

    // counter chunks, carry pipe, busy/hit shift registers and mode state
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            cy     <= '0;
            fl     <= '0;
            hp     <= '0;
            done   <= 1'b0;
            mode   <= 1'b0;
            period <= WIDTH'(DEFAULT_PERIOD);
        end else if (load) begin
            count  <= '0;
            cy     <= '0;
            fl     <= '0;
            hp     <= '0;
            done   <= 1'b0;
            mode   <= oneshot;
            period <= period_in;
        end else begin
            count <= wrap ? '0 : sum;
            cy    <= wrap ? '0 : cout;
            fl    <= (fl << 1) | CW'(acc);
            hp    <= hv[CHUNK_COUNT-1:0];
            done  <= done | (wrap & mode);
        end
    end

`ifdef CHUNKED_TIMER_OVERRUN_EN
    // sticky flag for ticks requested while the timer cannot take them
    always_ff @(posedge clk) begin
        if (rst | load)
            overrun <= 1'b0;
        else if (enable & (~ready | (done & mode)))
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_chunked_period_timer.sv
// tb_chunked_period_timer: directed checks of a 3-chunk and a 1-chunk timer instance.
module tb_chunked_period_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_en = 1'b0, a_ld = 1'b0, a_os = 1'b0;
    logic [11:0] a_pin = '0;
    logic        a_s, a_r, a_d, a_ov;
    logic [11:0] a_c;
    logic        b_en = 1'b0, b_ld = 1'b0, b_os = 1'b0;
    logic [7:0]  b_pin = '0;
    logic        b_s, b_r, b_d, b_ov;
    logic [7:0]  b_c;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          a_strobes = 0;

`ifdef CHUNKED_TIMER_OVERRUN_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif

    typedef struct {
        bit          sel;
        bit          en;
        bit          ld;
        bit          os;
        logic [11:0] pin;
        bit          s;
        bit          r;
        bit          d;
        logic [11:0] c;
        bit          chk_r;
        bit          chk_c;
    } vec_t;

    vec_t tbl[$];

    chunked_period_timer #(.WIDTH(12), .LATENCY(3), .DEFAULT_PERIOD(10)) u_a (
        .clk(clk), .rst(rst), .enable(a_en), .load(a_ld), .period_in(a_pin), .oneshot(a_os),
        .strobe(a_s), .ready(a_r), .done(a_d), .count(a_c), .overrun(a_ov)
    );

    chunked_period_timer #(.WIDTH(8), .LATENCY(1), .DEFAULT_PERIOD(10)) u_b (
        .clk(clk), .rst(rst), .enable(b_en), .load(b_ld), .period_in(b_pin), .oneshot(b_os),
        .strobe(b_s), .ready(b_r), .done(b_d), .count(b_c), .overrun(b_ov)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (a_s) a_strobes++;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit sel, input bit en, input bit ld, input bit os, input logic [11:0] pin,
                       input bit s, input bit r, input bit d, input logic [11:0] c,
                       input bit chk_r, input bit chk_c);
        vec_t v;
        v.sel = sel; v.en = en; v.ld = ld; v.os = os; v.pin = pin;
        v.s = s; v.r = r; v.d = d; v.c = c; v.chk_r = chk_r; v.chk_c = chk_c;
        tbl.push_back(v);
    endtask

    // one tick on the 3-chunk timer followed by two idle cycles; k is the tick number in the period
    task automatic add_paced(input int k, input int per);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, (k % per) == 0, 1, 0, 12'(k % per), 1, 1);
    endtask

    task automatic pace_a(output bit s3);
        a_en = 1'b1;
        step();
        a_en = 1'b0;
        step();
        step();
        s3 = a_s;
    endtask

    initial begin
        bit s;
        int n0;
        // 1-chunk instance: period 1 held enable, period 3, period 0, one-shot period 2
        add(1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1);
        for (int k = 0; k < 6; k++) add(1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        add(1, 0, 1, 0, 3, 0, 1, 0, 0, 1, 1);
        for (int k = 1; k <= 6; k++) add(1, 1, 0, 0, 0, (k % 3) == 0, 1, 0, 12'(k % 3), 1, 1);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        add(1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 2, 0, 1, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        add(1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
        // 3-chunk instance: period 5 twice-through, reload with 7 one cycle after tick 4
        add(0, 0, 1, 0, 5, 0, 1, 0, 0, 1, 1);
        for (int k = 1; k <= 5; k++) add_paced(k, 5);
        for (int k = 1; k <= 3; k++) add_paced(k, 5);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 7, 0, 1, 0, 0, 1, 1);
        for (int k = 1; k <= 7; k++) add_paced(k, 7);
        add_paced(1, 7);

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst a strobe", a_s, 0);
        check("rst a ready", a_r, 1);
        check("rst a done", a_d, 0);
        check("rst a count", a_c, 0);
        check("rst a overrun", a_ov, 0);
        check("rst b strobe", b_s, 0);
        check("rst b ready", b_r, 1);
        check("rst b count", b_c, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            a_en  = tbl[i].sel ? 1'b0 : tbl[i].en;
            a_ld  = tbl[i].sel ? 1'b0 : tbl[i].ld;
            a_os  = tbl[i].sel ? 1'b0 : tbl[i].os;
            a_pin = tbl[i].sel ? 12'd0 : tbl[i].pin;
            b_en  = tbl[i].sel ? tbl[i].en : 1'b0;
            b_ld  = tbl[i].sel ? tbl[i].ld : 1'b0;
            b_os  = tbl[i].sel ? tbl[i].os : 1'b0;
            b_pin = tbl[i].sel ? tbl[i].pin[7:0] : 8'd0;
            step();
            check($sformatf("v%0d strobe", i), tbl[i].sel ? b_s : a_s, tbl[i].s);
            check($sformatf("v%0d done", i), tbl[i].sel ? b_d : a_d, tbl[i].d);
            if (tbl[i].chk_r) check($sformatf("v%0d ready", i), tbl[i].sel ? b_r : a_r, tbl[i].r);
            if (tbl[i].chk_c) check($sformatf("v%0d count", i), tbl[i].sel ? 12'(b_c) : a_c, tbl[i].c);
        end
        a_en = 1'b0; a_ld = 1'b0; a_os = 1'b0; a_pin = '0;
        b_en = 1'b0; b_ld = 1'b0; b_os = 1'b0; b_pin = '0;
        step();

        // one-shot of 256 ticks
        a_ld = 1'b1; a_pin = 12'h100; a_os = 1'b1;
        step();
        a_ld = 1'b0; a_os = 1'b0;
        n0 = a_strobes;
        for (int i = 1; i <= 256; i++) begin
            pace_a(s);
            if (i == 255) begin
                check("os count 255", a_c, 12'h0ff);
                check("os no early strobe", 64'(a_strobes - n0), 0);
            end
        end
        check("os strobe at 256", s, 1);
        check("os done", a_d, 1);
        check("os count 0", a_c, 0);
        a_en = 1'b1;
        repeat (4) step();
        a_en = 1'b0;
        step();
        check("os single strobe", 64'(a_strobes - n0), 1);
        check("os done held", a_d, 1);
        check("os count held", a_c, 0);
        check("os overrun", a_ov, OV);

        // reset while the 0x0FF -> 0x100 carry is in flight
        a_ld = 1'b1; a_pin = 12'h200;
        step();
        a_ld = 1'b0;
        check("ld clears overrun", a_ov, 0);
        for (int i = 1; i <= 255; i++) pace_a(s);
        check("pre-rst count", a_c, 12'h0ff);
        a_en = 1'b1;
        step();
        a_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid-rst count", a_c, 0);
        check("mid-rst strobe", a_s, 0);
        check("mid-rst ready", a_r, 1);
        step();
        check("mid-rst no late strobe", a_s, 0);
        n0 = a_strobes;
        for (int i = 1; i <= 10; i++) begin
            pace_a(s);
            if (i == 9) check("default period tick 9", s, 0);
        end
        check("default period tick 10", s, 1);
        check("default period count", a_c, 0);
        pace_a(s);
        check("default periodic resumes", a_c, 1);
        check("default period one strobe", 64'(a_strobes - n0), 1);

        // enable while ready is low
        a_en = 1'b1;
        step();
        step();
        a_en = 1'b0;
        check("overrun set", a_ov, OV);
        step();
        check("overrun ready back", a_r, 1);
        check("overrun count unaffected", a_c, 2);
        step();
        check("overrun sticky", a_ov, OV);
        a_ld = 1'b1; a_pin = 12'd10;
        step();
        a_ld = 1'b0;
        check("overrun cleared by load", a_ov, 0);
        check("b overrun idle", b_ov, OV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
